// File: rtl/fetch_redirect_ctrl_if.sv
// Front-end redirect bundle: hazard stall, the three redirect sources and
// the fetch-address / flush / status outputs of the redirect controller.
interface fetch_redirect_ctrl_if;
  logic        stall;
  logic        exc_req;
  logic [31:0] exc_vec;
  logic        mp_req;
  logic [31:0] mp_target;
  logic        bp_taken;
  logic [31:0] bp_target;
  logic [31:0] fetch_pc;
  logic        pc_write;
  logic        flush;
  logic        redirect_pending;
  logic [15:0] mp_count;
  logic        align_err;

  modport master (
    output stall, exc_req, exc_vec, mp_req, mp_target, bp_taken, bp_target,
    input  fetch_pc, pc_write, flush, redirect_pending, mp_count, align_err
  );

  modport slave (
    input  stall, exc_req, exc_vec, mp_req, mp_target, bp_taken, bp_target,
    output fetch_pc, pc_write, flush, redirect_pending, mp_count, align_err
  );
endinterface

// File: rtl/fetch_redirect_ctrl.sv
// Fetch-address redirect controller. Chooses the next fetch address from
// exception, mispredict, a redirect parked during a stall, the branch
// predictor or the sequential path, and drives a timed front-end flush.
module fetch_redirect_ctrl #(
  parameter logic [31:0] RESET_PC     = 32'h0000_0000,
  parameter int          FLUSH_CYCLES = 2
) (
  input logic                  clk,
  input logic                  rst,
  fetch_redirect_ctrl_if.slave bus
);
  typedef enum logic [1:0] {ST_RUN = 2'd0, ST_PEND = 2'd1, ST_FLUSH = 2'd2} state_t;

  localparam logic [2:0] FLUSH_INIT = 3'(FLUSH_CYCLES);

  // Fetch addresses are word aligned; low bits of a target are discarded.
  function automatic logic [31:0] word_align(input logic [31:0] t);
    return {t[31:2], 2'b00};
  endfunction

  function automatic logic misaligned(input logic [31:0] t);
    return (t[1:0] != 2'b00);
  endfunction

  state_t      state_r, state_s;
  logic [31:0] pc_r, pc_s;
  logic [2:0]  cnt_r, cnt_s;
  logic        pend_exc_r, pend_exc_s;
  logic [31:0] pend_tgt_r, pend_tgt_s;
  logic        flush_r, pend_flag_r, pc_write_r, align_err_r;
  logic [15:0] mp_count_r;

  logic        live_req_s, live_wins_s;
  logic [31:0] live_tgt_s;
  logic        write_s, redirect_s, redirect_mp_s, bp_load_s;
  logic [31:0] redirect_tgt_s;
  logic        load_misaligned_s, mp_inc_s;

  // Collapse the live exception/mispredict requests into one candidate.
  always_comb begin
    live_req_s = bus.exc_req | bus.mp_req;
    if (bus.exc_req) begin
      live_tgt_s = bus.exc_vec;
    end else begin
      live_tgt_s = bus.mp_target;
    end
    // A live request displaces the parked one unless only an mp meets a parked exception.
    live_wins_s = bus.exc_req | (bus.mp_req & ~pend_exc_r);
  end

  // Next-state, next fetch address and per-edge event flags.
  always_comb begin
    state_s        = state_r;
    pc_s           = pc_r;
    cnt_s          = cnt_r;
    pend_exc_s     = pend_exc_r;
    pend_tgt_s     = pend_tgt_r;
    write_s        = 1'b0;
    redirect_s     = 1'b0;
    redirect_mp_s  = 1'b0;
    redirect_tgt_s = 32'h0000_0000;
    bp_load_s      = 1'b0;

    case (state_r)
      ST_RUN, ST_FLUSH: begin
        if (bus.stall) begin
          if (live_req_s) begin
            state_s    = ST_PEND;
            pend_exc_s = bus.exc_req;
            pend_tgt_s = live_tgt_s;
            cnt_s      = 3'd0;
          end else begin
            state_s = state_r;
          end
        end else begin
          write_s = 1'b1;
          if (live_req_s) begin
            redirect_s     = 1'b1;
            redirect_mp_s  = ~bus.exc_req;
            redirect_tgt_s = live_tgt_s;
          end else if (bus.bp_taken && !flush_r) begin
            bp_load_s = 1'b1;
          end else begin
            bp_load_s = 1'b0;
          end
          if (!live_req_s && (state_r == ST_FLUSH)) begin
            if (cnt_r <= 3'd1) begin
              state_s = ST_RUN;
              cnt_s   = 3'd0;
            end else begin
              cnt_s = cnt_r - 3'd1;
            end
          end else begin
            cnt_s = cnt_r;
          end
        end
      end
      ST_PEND: begin
        if (bus.stall) begin
          if (live_wins_s) begin
            pend_exc_s = bus.exc_req;
            pend_tgt_s = live_tgt_s;
          end else begin
            pend_tgt_s = pend_tgt_r;
          end
        end else begin
          write_s    = 1'b1;
          redirect_s = 1'b1;
          if (live_wins_s) begin
            redirect_mp_s  = ~bus.exc_req;
            redirect_tgt_s = live_tgt_s;
          end else begin
            redirect_mp_s  = ~pend_exc_r;
            redirect_tgt_s = pend_tgt_r;
          end
        end
      end
      default: begin
        state_s = ST_RUN;
      end
    endcase

    if (redirect_s) begin
      pc_s       = word_align(redirect_tgt_s);
      state_s    = ST_FLUSH;
      cnt_s      = FLUSH_INIT;
      pend_exc_s = 1'b0;
      pend_tgt_s = 32'h0000_0000;
    end else if (bp_load_s) begin
      pc_s = word_align(bus.bp_target);
    end else if (write_s) begin
      pc_s = pc_r + 32'd4;
    end else begin
      pc_s = pc_r;
    end

    load_misaligned_s = (redirect_s & misaligned(redirect_tgt_s)) |
                        (bp_load_s & misaligned(bus.bp_target));
    mp_inc_s          = redirect_s & redirect_mp_s;
  end

  // State, address and status registers; reset overrides everything.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r     <= ST_RUN;
      pc_r        <= RESET_PC;
      cnt_r       <= 3'd0;
      pend_exc_r  <= 1'b0;
      pend_tgt_r  <= 32'h0000_0000;
      flush_r     <= 1'b0;
      pend_flag_r <= 1'b0;
      pc_write_r  <= 1'b0;
      mp_count_r  <= 16'h0000;
      align_err_r <= 1'b0;
    end else begin
      state_r     <= state_s;
      pc_r        <= pc_s;
      cnt_r       <= cnt_s;
      pend_exc_r  <= pend_exc_s;
      pend_tgt_r  <= pend_tgt_s;
      flush_r     <= (state_s == ST_FLUSH);
      pend_flag_r <= (state_s == ST_PEND);
      pc_write_r  <= write_s;
      if (mp_inc_s && (mp_count_r != 16'hFFFF)) begin
        mp_count_r <= mp_count_r + 16'd1;
      end else begin
        mp_count_r <= mp_count_r;
      end
      if (load_misaligned_s) begin
        align_err_r <= 1'b1;
      end else begin
        align_err_r <= align_err_r;
      end
    end
  end

  assign bus.fetch_pc         = pc_r;
  assign bus.pc_write         = pc_write_r;
  assign bus.flush            = flush_r;
  assign bus.redirect_pending = pend_flag_r;
  assign bus.mp_count         = mp_count_r;
  assign bus.align_err        = align_err_r;
endmodule

// File: tb/tb_fetch_redirect_ctrl.sv
// Bench for fetch_redirect_ctrl: directed vector table, hand-written
// corner sequences and randomized traffic against a priority-rank model.
module tb_fetch_redirect_ctrl;
  localparam logic [31:0] RESET_PC = 32'h0000_0000;
  localparam int          FLUSH    = 2;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  fetch_redirect_ctrl_if bus ();

  fetch_redirect_ctrl #(.RESET_PC(RESET_PC), .FLUSH_CYCLES(FLUSH)) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  int n_cmp = 0;
  int n_bad = 0;

  typedef struct {
    logic        rst, stall, exc;
    logic [31:0] ev;
    logic        mp;
    logic [31:0] mt;
    logic        bp;
    logic [31:0] bt;
    logic [31:0] pc;
    logic        fl, rp, pw;
    logic [15:0] cnt;
    logic        al;
  } vec_t;

  vec_t tbl [24];

  function automatic vec_t mk(input logic r, s, e, input logic [31:0] ev, input logic m,
                              input logic [31:0] mt, input logic b, input logic [31:0] bt,
                              input logic [31:0] pc, input logic fl, rp, pw,
                              input logic [15:0] cnt, input logic al);
    vec_t v;
    v.rst = r; v.stall = s; v.exc = e; v.ev = ev; v.mp = m; v.mt = mt; v.bp = b; v.bt = bt;
    v.pc = pc; v.fl = fl; v.rp = rp; v.pw = pw; v.cnt = cnt; v.al = al;
    return v;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic step(input logic r, s, e, input logic [31:0] ev, input logic m,
                      input logic [31:0] mt, input logic b, input logic [31:0] bt);
    rst = r; bus.stall = s; bus.exc_req = e; bus.exc_vec = ev;
    bus.mp_req = m; bus.mp_target = mt; bus.bp_taken = b; bus.bp_target = bt;
    @(posedge clk);
    #1;
  endtask

  task automatic chk_all(input string tag, input logic [31:0] pc, input logic fl, rp, pw,
                         input logic [15:0] cnt, input logic al);
    chk({tag, " fetch_pc"}, bus.fetch_pc, pc);
    chk({tag, " flush"}, 32'(bus.flush), 32'(fl));
    chk({tag, " redirect_pending"}, 32'(bus.redirect_pending), 32'(rp));
    chk({tag, " pc_write"}, 32'(bus.pc_write), 32'(pw));
    chk({tag, " mp_count"}, 32'(bus.mp_count), 32'(cnt));
    chk({tag, " align_err"}, 32'(bus.align_err), 32'(al));
  endtask

  // Reference model: each candidate next address gets a rank
  // (live exc 5, parked exc 4, live mp 3, parked mp 2, bp 1, sequential 0).
  logic [31:0] m_pc;
  int          m_fl_left;
  bit          m_pv, m_pmp, m_al, m_pw;
  logic [31:0] m_pt;
  int          m_cnt;

  task automatic model_step(input bit r, s, e, input logic [31:0] ev, input bit m,
                            input logic [31:0] mt, input bit b, input logic [31:0] bt);
    int          best;
    logic [31:0] tgt;
    bit          src_mp;
    if (r) begin
      m_pc = RESET_PC; m_fl_left = 0; m_pv = 0; m_pmp = 0; m_pt = 32'h0;
      m_cnt = 0; m_al = 0; m_pw = 0;
    end else begin
      best = 0; tgt = m_pc + 32'd4; src_mp = 0;
      if (!s && b && m_fl_left == 0) begin best = 1; tgt = bt; end
      if (m_pv && (m_pmp ? 2 : 4) > best) begin best = m_pmp ? 2 : 4; tgt = m_pt; src_mp = m_pmp; end
      if (m && 3 > best) begin best = 3; tgt = mt; src_mp = 1; end
      if (e) begin best = 5; tgt = ev; src_mp = 0; end
      if (s) begin
        m_pw = 0;
        if (best >= 2) begin m_pv = 1; m_pmp = src_mp; m_pt = tgt; m_fl_left = 0; end
      end else begin
        m_pw = 1;
        if (best >= 1 && tgt[1:0] != 2'b00) m_al = 1;
        m_pc = {tgt[31:2], 2'b00};
        if (best >= 2) begin
          m_fl_left = FLUSH; m_pv = 0;
          if (src_mp && m_cnt < 65535) m_cnt++;
        end else if (m_fl_left > 0) begin
          m_fl_left--;
        end
      end
    end
  endtask

  initial begin
    // rst stall exc ev mp mt bp bt | pc fl rp pw cnt al
    tbl[0]  = mk(1,0,0,32'h0,0,32'h0,0,32'h0,  32'h0,  0,0,0,16'd0,0);
    tbl[1]  = mk(0,0,0,32'h0,0,32'h0,0,32'h0,  32'h4,  0,0,1,16'd0,0);
    tbl[2]  = mk(0,0,0,32'h0,0,32'h0,0,32'h0,  32'h8,  0,0,1,16'd0,0);
    tbl[3]  = mk(0,0,0,32'h0,0,32'h0,0,32'h0,  32'hC,  0,0,1,16'd0,0);
    tbl[4]  = mk(0,0,0,32'h0,0,32'h0,0,32'h0,  32'h10, 0,0,1,16'd0,0);
    tbl[5]  = mk(0,0,0,32'h0,1,32'h200,0,32'h0,32'h200,1,0,1,16'd1,0);
    tbl[6]  = mk(0,0,0,32'h0,0,32'h0,0,32'h0,  32'h204,1,0,1,16'd1,0);
    tbl[7]  = mk(0,0,0,32'h0,0,32'h0,0,32'h0,  32'h208,0,0,1,16'd1,0);
    tbl[8]  = mk(1,0,0,32'h0,0,32'h0,0,32'h0,  32'h0,  0,0,0,16'd0,0);
    tbl[9]  = mk(0,1,0,32'h0,1,32'h300,0,32'h0,32'h0,  0,1,0,16'd0,0);
    tbl[10] = mk(0,1,1,32'h80,0,32'h0,0,32'h0, 32'h0,  0,1,0,16'd0,0);
    tbl[11] = mk(0,0,0,32'h0,0,32'h0,0,32'h0,  32'h80, 1,0,1,16'd0,0);
    tbl[12] = mk(0,0,0,32'h0,0,32'h0,0,32'h0,  32'h84, 1,0,1,16'd0,0);
    tbl[13] = mk(0,0,0,32'h0,0,32'h0,0,32'h0,  32'h88, 0,0,1,16'd0,0);
    tbl[14] = mk(0,0,1,32'h80,1,32'h300,1,32'h400,32'h80,1,0,1,16'd0,0);
    tbl[15] = mk(0,0,0,32'h0,0,32'h0,1,32'h400,32'h84, 1,0,1,16'd0,0);
    tbl[16] = mk(0,0,0,32'h0,0,32'h0,0,32'h0,  32'h88, 0,0,1,16'd0,0);
    tbl[17] = mk(0,0,0,32'h0,0,32'h0,1,32'h400,32'h400,0,0,1,16'd0,0);
    tbl[18] = mk(0,0,0,32'h0,1,32'h203,0,32'h0,32'h200,1,0,1,16'd1,1);
    tbl[19] = mk(0,0,0,32'h0,0,32'h0,0,32'h0,  32'h204,1,0,1,16'd1,1);
    tbl[20] = mk(0,0,0,32'h0,0,32'h0,0,32'h0,  32'h208,0,0,1,16'd1,1);
    tbl[21] = mk(0,1,0,32'h0,1,32'h500,0,32'h0,32'h208,0,1,0,16'd1,1);
    tbl[22] = mk(1,1,0,32'h0,1,32'h500,0,32'h0,32'h0,  0,0,0,16'd0,0);
    tbl[23] = mk(0,0,0,32'h0,0,32'h0,0,32'h0,  32'h4,  0,0,1,16'd0,0);

    for (int i = 0; i < 24; i++) begin
      step(tbl[i].rst, tbl[i].stall, tbl[i].exc, tbl[i].ev, tbl[i].mp, tbl[i].mt, tbl[i].bp, tbl[i].bt);
      chk_all($sformatf("row%0d", i), tbl[i].pc, tbl[i].fl, tbl[i].rp, tbl[i].pw, tbl[i].cnt, tbl[i].al);
    end

    // Redirect during flush restarts the count; stall freezes it.
    step(1,0,0,32'h0,0,32'h0,0,32'h0);
    step(0,0,0,32'h0,1,32'h100,0,32'h0);  chk_all("rst_a1", 32'h100, 1,0,1,16'd1,0);
    step(0,0,0,32'h0,0,32'h0,0,32'h0);    chk_all("rst_a2", 32'h104, 1,0,1,16'd1,0);
    step(0,0,1,32'h40,0,32'h0,0,32'h0);   chk_all("rst_a3", 32'h40,  1,0,1,16'd1,0);
    for (int k = 0; k < 3; k++) begin
      step(0,1,0,32'h0,0,32'h0,1,32'h900); chk_all($sformatf("frz%0d", k), 32'h40, 1,0,0,16'd1,0);
    end
    step(0,0,0,32'h0,0,32'h0,0,32'h0);    chk_all("rst_a4", 32'h44,  1,0,1,16'd1,0);
    step(0,0,0,32'h0,0,32'h0,0,32'h0);    chk_all("rst_a5", 32'h48,  0,0,1,16'd1,0);

    // Parked-redirect arbitration: equal overwrites, lower is dropped.
    step(0,1,0,32'h0,1,32'h300,0,32'h0);  chk_all("pend_b1", 32'h48, 0,1,0,16'd1,0);
    step(0,1,0,32'h0,1,32'h310,0,32'h0);  chk_all("pend_b2", 32'h48, 0,1,0,16'd1,0);
    step(0,0,0,32'h0,0,32'h0,0,32'h0);    chk_all("pend_b3", 32'h310,1,0,1,16'd2,0);
    step(0,1,1,32'h80,0,32'h0,0,32'h0);   chk_all("pend_b4", 32'h310,0,1,0,16'd2,0);
    step(0,1,0,32'h0,1,32'h998,0,32'h0);  chk_all("pend_b5", 32'h310,0,1,0,16'd2,0);
    step(0,0,0,32'h0,1,32'h778,0,32'h0);  chk_all("pend_b6", 32'h80, 1,0,1,16'd2,0);

    // Sequential path wraps at the top of the address space.
    step(0,0,1,32'hFFFF_FFF8,0,32'h0,0,32'h0); chk_all("wrap1", 32'hFFFF_FFF8,1,0,1,16'd2,0);
    step(0,0,0,32'h0,0,32'h0,0,32'h0);         chk_all("wrap2", 32'hFFFF_FFFC,1,0,1,16'd2,0);
    step(0,0,0,32'h0,0,32'h0,0,32'h0);         chk_all("wrap3", 32'h0000_0000,0,0,1,16'd2,0);

    // Randomized traffic against the rank model.
    model_step(1,0,0,32'h0,0,32'h0,0,32'h0);
    step(1,0,0,32'h0,0,32'h0,0,32'h0);
    for (int n = 0; n < 3000; n++) begin
      bit r, s, e, m, b;
      logic [31:0] ev, mt, bt;
      r = ($urandom_range(63) == 0);
      s = ($urandom_range(3) == 0);
      e = ($urandom_range(9) == 0);
      m = ($urandom_range(5) == 0);
      b = ($urandom_range(3) == 0);
      ev = $urandom; mt = $urandom; bt = $urandom;
      if ($urandom_range(7) != 0) ev[1:0] = 2'b00;
      if ($urandom_range(7) != 0) mt[1:0] = 2'b00;
      if ($urandom_range(7) != 0) bt[1:0] = 2'b00;
      if ($urandom_range(15) != 0 && !r) begin
        m_al = m_al;
      end
      model_step(r, s, e, ev, m, mt, b, bt);
      step(r, s, e, ev, m, mt, b, bt);
      chk_all($sformatf("rnd%0d", n), m_pc, (m_fl_left > 0), m_pv, m_pw, 16'(m_cnt), m_al);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
